mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Control unit for the multicycle ARM-subset datapath. Decodes the latched instruction and runs a Moore main FSM (FETCH → DECODE → execute/memory → writeback). Drives every datapath select and enable. Holds the NZCV flags register and gates architectural writes with the instruction's condition field.

Parameters:
FLAGS_RESET, 4'b0000, value loaded into the {N,Z,C,V} flags register on reset

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
Instr  in  32  latched instruction from the IR; uses Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
ALUFlags  in  4  live ALU flags {N,Z,C,V}
PCWrite  out  1  PC register enable
MemWrite  out  1  data memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  memory address select: 0=PC, 1=Result
RegSrc  out  2  [0]=1 reads R15 on RA1 (branch); [1]=1 reads Rd on RA2 (store)
ALUSrcA  out  1  0=A register, 1=PC
ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  out  2  equal to Op
ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR

Behaviour:
- States are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; no writes.
  - Op=01 → MEMADR.
  - Op=00 with Funct[5]=0 → EXECUTER; with Funct[5]=1 → EXECUTEI.
  - Op=10 → BRANCH.
  - Op=11 → FETCH (treated as a NOP).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD if Funct[3] (U bit) else SUB. Funct[0]=1 → MEMREAD; Funct[0]=0 → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Next state FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=CondEx. Next state FETCH.
- EXECUTER / EXECUTEI: ALUSrcA=0, ALUSrcB=00 (R) or 01 (I). ALUControl decoded from Funct[4:1]:
  - ADD 0100, SUB 0010, CMP 1010 (SUB), AND 0000, ORR 1100, EOR 0001.
  - Any other cmd uses ADD with no register or flag write.
  - Next state ALUWB.
- ALUWB: ResultSrc=00; RegWrite=CondEx & ~NoWrite, where NoWrite is set for CMP. If Rd=15 and the write is enabled, PCWrite=1 as well. Next state FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUControl=ADD, PCWrite=CondEx. Next state FETCH.
- RegSrc and ImmSrc are combinational from Op in every state. ALUControl is ADD in every state not listed above.
- Flags:
  - Updated on the clock edge leaving EXECUTER/EXECUTEI, only when Funct[0] (S bit)=1 and CondEx=1.
  - ADD/SUB/CMP update all of NZCV. AND/ORR/EOR update N,Z only.
- CondEx: combinational from Cond and the registered flags.
  - Codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - Cond=1111 evaluates to 0.
- Instruction latencies: data-processing 4 cycles, LDR 5, STR 4, B 3, NOP (Op=11) 2.
- A false condition still walks the full state path with writes suppressed. PC advances normally.
- Reset:
  - State=FETCH, flags=FLAGS_RESET.
  - While reset=1, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0; select outputs take their FETCH values.
  - Reset mid-instruction abandons it with no partial write on the reset cycle.

Decomposition:
- Shared package holds:
  - the state enum;
  - ALUControl encodings;
  - ALUSrcB and ResultSrc select constants;
  - the Cond code constants;
  - the Op and data-processing cmd constants.
- One sub-module, cond_unit: owns the flags register and flag-write masking, and computes CondEx. The FSM and decoder stay in mc_control_fsm.

Test Plan:
- Reset 3 cycles, then release with Instr=E0821003 (ADD R1,R2,R3) → states FETCH, DECODE, EXECUTER, ALUWB. IRWrite=1 only in cycle 0, RegWrite=1 only in cycle 3, ALUControl=000 in cycle 2.
- Instr=E5910004 (LDR R0,[R1,#4]) → 5-cycle path. MEMADR shows ALUSrcB=01, ALUControl=ADD. MEMREAD shows AdrSrc=1. RegWrite=1 with ResultSrc=01 in MEMWB.
- Instr=E5810004 (STR) → MemWrite=1 only in MEMWRITE, RegSrc=10, RegWrite never asserted.
- SUBS with ALUFlags=0100 in EXECUTER, then Instr=1A000002 (BNE) → Z=1 latched, BNE not taken: PCWrite=0 in BRANCH. Repeat with ALUFlags=0000 → PCWrite=1.
- Instr=E08FF003 (ADD PC,PC,R3) → both RegWrite=1 and PCWrite=1 in ALUWB. Instr=E3530000 (CMP) → RegWrite=0 in ALUWB, flags updated.
- Assert reset while in MEMWRITE → MemWrite=0 on that cycle. Next state is FETCH and flags return to 0000.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// States, datapath select codes, condition codes and instruction field values.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/mc_control_fsm_cond_unit.sv
// NZCV flags register with per-group write masking, and the condition
// evaluator that decides whether the current instruction may commit.
module mc_control_fsm_cond_unit
    import mc_control_fsm_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_write,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // flag_write[1] covers N,Z; flag_write[0] covers C,V (arithmetic only).
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= FLAGS_RESET;
        end else begin
            if (flag_write[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_write[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM and instruction decoder for the multicycle datapath.
// Drives all selects/enables; architectural writes are gated by CondEx.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);

    state_t     state;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       cond_ex;
    logic [3:0] flags;
    logic [1:0] flag_write;
    logic [2:0] dp_ctrl;
    logic       dp_valid;
    logic       dp_arith;
    logic       no_write;
    logic       dp_commit;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign funct        = Instr[25:20];
    assign rd           = Instr[15:12];
    assign cmd          = funct[4:1];
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    assign RegSrc = {op == OP_MEM, op == OP_BR};
    assign ImmSrc = op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_MEM:  state <= S_MEMADR;
                        OP_DP:   state <= funct[5] ? S_EXECUTEI : S_EXECUTER;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state <= S_MEMWB;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Unrecognised commands fall back to ADD and never write registers or flags.
    always_comb begin
        dp_ctrl  = ALU_ADD;
        dp_valid = 1'b1;
        dp_arith = 1'b0;
        no_write = 1'b0;
        case (cmd)
            CMD_ADD: begin dp_ctrl = ALU_ADD; dp_arith = 1'b1; end
            CMD_SUB: begin dp_ctrl = ALU_SUB; dp_arith = 1'b1; end
            CMD_CMP: begin dp_ctrl = ALU_SUB; dp_arith = 1'b1; no_write = 1'b1; end
            CMD_AND: dp_ctrl = ALU_AND;
            CMD_ORR: dp_ctrl = ALU_ORR;
            CMD_EOR: dp_ctrl = ALU_EOR;
            default: dp_valid = 1'b0;
        endcase
    end

    assign flag_write = ((state == S_EXECUTER || state == S_EXECUTEI) && funct[0] && dp_valid)
                        ? {1'b1, dp_arith} : 2'b00;
    assign dp_commit  = cond_ex & dp_valid & ~no_write;

    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_WD;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        if (reset) begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
        end else begin
            case (state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                S_DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                S_MEMADR: begin
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = cond_ex;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = cond_ex;
                end
                S_EXECUTER: ALUControl = dp_ctrl;
                S_EXECUTEI: begin
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = dp_ctrl;
                end
                S_ALUWB: begin
                    RegWrite = dp_commit;
                    PCWrite  = dp_commit & (rd == 4'hF);
                end
                S_BRANCH: begin
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALURESULT;
                    PCWrite   = cond_ex;
                end
                default: ;
            endcase
        end
    end

    mc_control_fsm_cond_unit #(
        .FLAGS_RESET(FLAGS_RESET)
    ) u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (Instr[31:28]),
        .alu_flags (ALUFlags),
        .flag_write(flag_write),
        .cond_ex   (cond_ex),
        .flags     (flags)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, select-level sequences,
// mid-instruction reset, and random instructions against an instruction-level model.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.FLAGS_RESET(4'b0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .Instr     (Instr),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .RegSrc    (RegSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .ALUControl(ALUControl)
    );

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  af;
        int          len;
        logic [7:0]  rw;
        logic [7:0]  mw;
        logic [7:0]  pw;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[15];

    // per-cycle samples of the most recent instruction
    logic [1:0] s_srcb[8], s_res[8], s_regsrc[8], s_imm[8];
    logic [2:0] s_ctl[8];
    logic       s_adr[8], s_srca[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one instruction starting in FETCH; stops when the next FETCH shows up.
    task automatic exec(input logic [31:0] ins, input logic [3:0] af, output int len,
                        output logic [7:0] rw, output logic [7:0] mw,
                        output logic [7:0] pw, output logic [7:0] iw);
        Instr    = ins;
        ALUFlags = af;
        rw = '0; mw = '0; pw = '0; iw = '0; len = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rw[c] = RegWrite; mw[c] = MemWrite; pw[c] = PCWrite; iw[c] = IRWrite;
            s_srcb[c] = ALUSrcB; s_res[c] = ResultSrc; s_regsrc[c] = RegSrc;
            s_imm[c] = ImmSrc; s_ctl[c] = ALUControl; s_adr[c] = AdrSrc; s_srca[c] = ALUSrcA;
            len = c + 1;
            @(posedge clk);
            #1;
            if (IRWrite) break;
        end
    endtask

    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b0;
        if (cond == 4'hE) return 1'b1;
        return base ^ cond[0];
    endfunction

    // Instruction-level model: cycle count, per-cycle write strobes, resulting flags.
    task automatic predict(input logic [31:0] ins, input logic [3:0] af, input logic [3:0] f_in,
                           output int len, output logic [7:0] rw, output logic [7:0] mw,
                           output logic [7:0] pw, output logic [3:0] f_out);
        logic [3:0] cond, cmd, rd;
        logic [5:0] funct;
        logic       ce, writes, logic_op, known;
        cond  = ins[31:28];
        funct = ins[25:20];
        cmd   = funct[4:1];
        rd    = ins[15:12];
        ce    = cond_true(cond, f_in);
        rw = '0; mw = '0; pw = 8'h01; f_out = f_in; len = 2;
        logic_op = (cmd == 4'b0000) || (cmd == 4'b1100) || (cmd == 4'b0001);
        known    = logic_op || (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        writes   = known && (cmd != 4'b1010);
        case (ins[27:26])
            2'b00: begin
                len = 4;
                if (known && funct[0] && ce)
                    f_out = logic_op ? {af[3:2], f_in[1:0]} : af;
                if (writes && cond_true(cond, f_out)) begin
                    rw[3] = 1'b1;
                    if (rd == 4'hF) pw[3] = 1'b1;
                end
            end
            2'b01: begin
                if (funct[0]) begin len = 5; rw[4] = ce; end
                else begin len = 4; mw[3] = ce; end
            end
            2'b10: begin len = 3; pw[2] = ce; end
            default: len = 2;
        endcase
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         len, e_len;
        logic [7:0] rw, mw, pw, iw, e_rw, e_mw, e_pw;
        logic [3:0] m_flags, e_flags, af;
        logic [31:0] ins;

        vecs[0]  = '{32'hE0821003, 4'h0, 4, 8'h08, 8'h00, 8'h01, 4'h0};
        vecs[1]  = '{32'hE5910004, 4'h0, 5, 8'h10, 8'h00, 8'h01, 4'h0};
        vecs[2]  = '{32'hE5810004, 4'h0, 4, 8'h00, 8'h08, 8'h01, 4'h0};
        vecs[3]  = '{32'hE0521003, 4'h4, 4, 8'h08, 8'h00, 8'h01, 4'h4};
        vecs[4]  = '{32'h1A000002, 4'h0, 3, 8'h00, 8'h00, 8'h01, 4'h4};
        vecs[5]  = '{32'hE0521003, 4'h0, 4, 8'h08, 8'h00, 8'h01, 4'h0};
        vecs[6]  = '{32'h1A000002, 4'h0, 3, 8'h00, 8'h00, 8'h05, 4'h0};
        vecs[7]  = '{32'hE08FF003, 4'h0, 4, 8'h08, 8'h00, 8'h09, 4'h0};
        vecs[8]  = '{32'hE3530000, 4'h8, 4, 8'h00, 8'h00, 8'h01, 4'h8};
        vecs[9]  = '{32'hEC000000, 4'hF, 2, 8'h00, 8'h00, 8'h01, 4'h8};
        vecs[10] = '{32'hE0110002, 4'hF, 4, 8'h08, 8'h00, 8'h01, 4'hC};
        vecs[11] = '{32'h00821003, 4'h0, 4, 8'h08, 8'h00, 8'h01, 4'hC};
        vecs[12] = '{32'h10821003, 4'h0, 4, 8'h00, 8'h00, 8'h01, 4'hC};
        vecs[13] = '{32'hE1F01002, 4'h3, 4, 8'h00, 8'h00, 8'h01, 4'hC};
        vecs[14] = '{32'hF0821003, 4'h5, 4, 8'h00, 8'h00, 8'h01, 4'hC};

        // clock/reset
        reset = 1'b1; Instr = 32'hE0821003; ALUFlags = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pcwrite", PCWrite, 0);
        check("reset_irwrite", IRWrite, 0);
        check("reset_memwrite", MemWrite, 0);
        check("reset_regwrite", RegWrite, 0);
        check("reset_srca", ALUSrcA, 1);
        check("reset_srcb", ALUSrcB, 2'b10);
        check("reset_ressrc", ResultSrc, 2'b10);
        check("reset_adrsrc", AdrSrc, 0);
        check("reset_aluctl", ALUControl, 3'b000);
        check("reset_flags", dut.flags, 4'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // directed table
        for (int i = 0; i < 15; i++) begin
            exec(vecs[i].instr, vecs[i].af, len, rw, mw, pw, iw);
            check($sformatf("vec%0d_len", i), len, vecs[i].len);
            check($sformatf("vec%0d_regwrite", i), rw, vecs[i].rw);
            check($sformatf("vec%0d_memwrite", i), mw, vecs[i].mw);
            check($sformatf("vec%0d_pcwrite", i), pw, vecs[i].pw);
            check($sformatf("vec%0d_irwrite", i), iw, 8'h01);
            check($sformatf("vec%0d_flags", i), dut.flags, vecs[i].flags);
        end

        // select-level sequences
        exec(32'hE0821003, 4'h0, len, rw, mw, pw, iw);
        check("add_decode_srcb", s_srcb[1], 2'b10);
        check("add_decode_res", s_res[1], 2'b10);
        check("add_exec_ctl", s_ctl[2], 3'b000);
        check("add_exec_srcb", s_srcb[2], 2'b00);
        check("add_exec_srca", s_srca[2], 0);
        check("add_aluwb_res", s_res[3], 2'b00);
        exec(32'hE5910004, 4'h0, len, rw, mw, pw, iw);
        check("ldr_immsrc", s_imm[0], 2'b01);
        check("ldr_memadr_srcb", s_srcb[2], 2'b01);
        check("ldr_memadr_ctl", s_ctl[2], 3'b000);
        check("ldr_memread_adr", s_adr[3], 1);
        check("ldr_memwb_res", s_res[4], 2'b01);
        exec(32'hE5110004, 4'h0, len, rw, mw, pw, iw);
        check("ldr_down_ctl", s_ctl[2], 3'b001);
        exec(32'hE5810004, 4'h0, len, rw, mw, pw, iw);
        check("str_regsrc", s_regsrc[3], 2'b10);
        check("str_memwrite_adr", s_adr[3], 1);
        exec(32'hE0421003, 4'h0, len, rw, mw, pw, iw);
        check("sub_ctl", s_ctl[2], 3'b001);
        exec(32'hE3530000, 4'hC, len, rw, mw, pw, iw);
        check("cmp_imm_srcb", s_srcb[2], 2'b01);
        check("cmp_ctl", s_ctl[2], 3'b001);
        exec(32'hE0010002, 4'h0, len, rw, mw, pw, iw);
        check("and_ctl", s_ctl[2], 3'b010);
        exec(32'hE1810002, 4'h0, len, rw, mw, pw, iw);
        check("orr_ctl", s_ctl[2], 3'b011);
        exec(32'hE0210002, 4'h0, len, rw, mw, pw, iw);
        check("eor_ctl", s_ctl[2], 3'b100);
        exec(32'hEA000002, 4'h0, len, rw, mw, pw, iw);
        check("b_regsrc", s_regsrc[0], 2'b01);
        check("b_branch_srcb", s_srcb[2], 2'b01);
        check("b_branch_res", s_res[2], 2'b10);
        check("b_branch_ctl", s_ctl[2], 3'b000);
        check("b_pcwrite", pw, 8'h05);
        // set flags nonzero so the reset below visibly clears them
        exec(32'hE0521003, 4'h6, len, rw, mw, pw, iw);
        check("pre_reset_flags", dut.flags, 4'h6);

        // reset while in MEMWRITE
        Instr = 32'hE5810004; ALUFlags = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("memwrite_before_reset", MemWrite, 1);
        reset = 1'b1;
        #1;
        check("memwrite_in_reset", MemWrite, 0);
        check("pcwrite_in_reset", PCWrite, 0);
        check("srcb_in_reset", ALUSrcB, 2'b10);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("fetch_after_reset", IRWrite, 1);
        check("flags_after_reset", dut.flags, 4'h0);

        // random instructions against the model
        m_flags = 4'h0;
        for (int i = 0; i < 200; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
            af = 4'($urandom_range(0, 15));
            predict(ins, af, m_flags, e_len, e_rw, e_mw, e_pw, e_flags);
            exec(ins, af, len, rw, mw, pw, iw);
            check($sformatf("rnd%0d_%08h_len", i, ins), len, e_len);
            check($sformatf("rnd%0d_%08h_regwrite", i, ins), rw, e_rw);
            check($sformatf("rnd%0d_%08h_memwrite", i, ins), mw, e_mw);
            check($sformatf("rnd%0d_%08h_pcwrite", i, ins), pw, e_pw);
            check($sformatf("rnd%0d_%08h_flags", i, ins), dut.flags, e_flags);
            m_flags = e_flags;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
